wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive lost cycles of the multi-cycle requester before the pipeline is forced to stall.
REQ-002 i_clk  input  1 (type clock)  single clock; all state updates on posedge.
REQ-003 i_rst  input  1  reset; asynchronous, active-high.
REQ-004 i_pl_wr_en  input  1  pipeline writeback request.
REQ-005 i_pl_wr_addr  input  5 (reg_addr)  pipeline destination register.
REQ-006 i_pl_wr_val  input  32 (data_val)  pipeline write data.
REQ-007 i_mc_valid  input  1  multi-cycle unit (mul/div) write request.
REQ-008 i_mc_addr  input  5 (reg_addr)  multi-cycle destination register.
REQ-009 i_mc_val  input  32 (data_val)  multi-cycle write data.
REQ-010 o_mc_ready  output  1  combinational accept for the multi-cycle request this cycle.
REQ-011 o_pl_stall  output  1  freeze request to the pipeline front end.
REQ-012 o_reg_wr_en  output  1  register-file write enable.
REQ-013 o_reg_wr_addr  output  5 (reg_addr)  register-file write address.
REQ-014 o_reg_wr_val  output  32 (data_val)  register-file write data.

Function
REQ-015 Pipeline request is live only if i_pl_wr_en=1 and i_pl_wr_addr!=0; a pipeline write to x0 is discarded.
REQ-016 Grant per cycle: in FORCE, the multi-cycle unit wins; otherwise a live pipeline request wins; otherwise i_mc_valid wins.
REQ-017 o_mc_ready=1 exactly in cycles where the multi-cycle unit is granted; a transfer occurs when i_mc_valid and o_mc_ready are both 1.
REQ-018 The multi-cycle unit holds i_mc_valid, i_mc_addr and i_mc_val stable until the transfer; the bench asserts this.
REQ-019 A granted multi-cycle write to x0 is accepted (o_mc_ready=1) but produces o_reg_wr_en=0.
REQ-020 Output registers: the granted address and data appear on o_reg_wr_* on the cycle after the grant, with o_reg_wr_en=1; latency is exactly 1 cycle; o_reg_wr_en=0 when no write was granted.
REQ-021 FSM states: IDLE (no multi-cycle request waiting), WAIT (request present and losing), FORCE (forced multi-cycle grant).
REQ-022 IDLE->WAIT when i_mc_valid=1 and the pipeline wins; IDLE stays IDLE otherwise.
REQ-023 8-bit starve counter: cleared in IDLE and on each transfer; incremented each cycle in WAIT that the pipeline wins.
REQ-024 WAIT->IDLE on transfer; WAIT->FORCE when the counter equals STARVE_LIMIT at a clock edge while i_mc_valid=1.
REQ-025 FORCE lasts exactly one cycle: o_pl_stall=1, multi-cycle granted, pipeline request ignored (upstream re-presents it after the stall); FORCE->IDLE.
REQ-026 o_pl_stall=1 only in FORCE and is driven from state (glitch-free, no combinational path from inputs).
REQ-027 Simultaneous pipeline and multi-cycle requests to the same address outside FORCE: the pipeline writes first, the multi-cycle write follows, and the later write wins in the register file.

Reset
REQ-028 While i_rst=1: FSM=IDLE, counter=0, o_reg_wr_en=0, o_reg_wr_addr=0, o_reg_wr_val=0, o_pl_stall=0, o_mc_ready=0.
REQ-029 Reset asserted mid-WAIT or mid-FORCE drops the pending grant with no write issued; the multi-cycle unit re-requests after reset.

Structure
REQ-030 Types clock, data_val and reg_addr, and the FSM state enum, shall come from the shared core package; the STARVE_LIMIT default shall be a package constant.
REQ-031 No sub-module: the FSM, counter and output registers are in one module.

Verification
REQ-032 Pipeline write x5=0x0000_00AA with no multi-cycle request -> next cycle o_reg_wr_en=1, addr=5, val=0xAA; o_mc_ready=0.
REQ-033 Multi-cycle valid x7=0x1234 with the pipeline idle -> o_mc_ready=1 the same cycle; write to x7 the next cycle.
REQ-034 Pipeline writes every cycle and multi-cycle valid x9=0x55 held -> 4 pipeline wins, then o_pl_stall=1 for 1 cycle with o_mc_ready=1, x9 written, then IDLE.
REQ-035 Pipeline write x0=0xFFFF_FFFF -> o_reg_wr_en=0; multi-cycle x0 -> o_mc_ready=1, o_reg_wr_en=0.
REQ-036 Pipeline and multi-cycle both target x3 (0x1, 0x2) in the same cycle -> x3=0x1 in cycle+1, x3=0x2 in cycle+2.
REQ-037 i_rst pulsed in WAIT with counter=3 -> all outputs 0 immediately; FSM IDLE, no write issued.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared core types for the register-file write-port arbiter: data/address
// types, the arbiter FSM state encoding and the default starvation limit.
package wb_port_arbiter_pkg;

  typedef logic        clock;
  typedef logic [31:0] data_val;
  typedef logic [4:0]  reg_addr;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
  localparam int unsigned STARVE_CNT_W         = 8;

endpackage

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline writeback
// and a multi-cycle (mul/div) unit, forcing a one-cycle pipeline stall on starvation.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  clock        i_clk,
  input  logic        i_rst,
  input  logic        i_pl_wr_en,
  input  reg_addr     i_pl_wr_addr,
  input  data_val     i_pl_wr_val,
  input  logic        i_mc_valid,
  input  reg_addr     i_mc_addr,
  input  data_val     i_mc_val,
  output logic        o_mc_ready,
  output logic        o_pl_stall,
  output logic        o_reg_wr_en,
  output reg_addr     o_reg_wr_addr,
  output data_val     o_reg_wr_val,
  output logic [1:0]  o_dbg_state
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_e              state_q;
  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;
  logic                    stall_q;
  logic                    wr_en_q;
  reg_addr                 wr_addr_q;
  data_val                 wr_val_q;

  logic pl_live;
  logic force_now;
  logic mc_grant;
  logic pl_grant;
  logic mc_xfer;

  // Handshake: the multi-cycle unit raises i_mc_valid and holds addr/val stable;
  // o_mc_ready is the same-cycle grant and a transfer happens when both are 1.
  assign pl_live   = i_pl_wr_en && (i_pl_wr_addr != '0);
  assign force_now = (state_q == ST_FORCE);
  assign mc_grant  = force_now || (i_mc_valid && !pl_live);
  assign pl_grant  = pl_live && !force_now;
  assign mc_xfer   = i_mc_valid && mc_grant;
  assign cnt_d     = cnt_q + 1'b1;

  assign o_mc_ready    = mc_grant && !i_rst;
  assign o_pl_stall    = stall_q;
  assign o_reg_wr_en   = wr_en_q;
  assign o_reg_wr_addr = wr_addr_q;
  assign o_reg_wr_val  = wr_val_q;
  assign o_dbg_state   = state_q;

  // The counter holds lost cycles of the current request, including the one
  // that left IDLE, so STARVE_LIMIT losses are followed directly by FORCE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      stall_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_val_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      stall_q <= 1'b0;
      if (pl_grant) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= i_pl_wr_addr;
        wr_val_q  <= i_pl_wr_val;
      end else if (mc_xfer) begin
        wr_en_q   <= (i_mc_addr != '0);
        wr_addr_q <= i_mc_addr;
        wr_val_q  <= i_mc_val;
      end

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (i_mc_valid && pl_live) begin
            cnt_q <= cnt_d;
            if (cnt_d == LIMIT) begin
              state_q <= ST_FORCE;
              stall_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!i_mc_valid || mc_xfer) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == LIMIT) begin
              state_q <= ST_FORCE;
              stall_q <= 1'b1;
            end
          end
        end
        ST_FORCE: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by
// randomized traffic, scored against a lost-cycle reference model.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int unsigned LIMIT = STARVE_LIMIT_DEFAULT;

  logic        i_clk;
  logic        i_rst;
  logic        i_pl_wr_en;
  logic [4:0]  i_pl_wr_addr;
  logic [31:0] i_pl_wr_val;
  logic        i_mc_valid;
  logic [4:0]  i_mc_addr;
  logic [31:0] i_mc_val;
  logic        o_mc_ready;
  logic        o_pl_stall;
  logic        o_reg_wr_en;
  logic [4:0]  o_reg_wr_addr;
  logic [31:0] o_reg_wr_val;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: one entry per cycle {wr_en, addr, val} expected on the
  // cycle after; lost counts consecutive cycles the pending mc request lost.
  logic [37:0] exp_q[$];
  int          lost = 0;
  logic        last_mc_taken;

  // Multi-cycle requester agent state for the random phase
  logic        mc_pend = 1'b0;
  logic [4:0]  mc_a;
  logic [31:0] mc_v;

  // Protocol monitor state
  logic        held_pend = 1'b0;
  logic [4:0]  held_a;
  logic [31:0] held_v;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pl_wr_en   (i_pl_wr_en),
    .i_pl_wr_addr (i_pl_wr_addr),
    .i_pl_wr_val  (i_pl_wr_val),
    .i_mc_valid   (i_mc_valid),
    .i_mc_addr    (i_mc_addr),
    .i_mc_val     (i_mc_val),
    .o_mc_ready   (o_mc_ready),
    .o_pl_stall   (o_pl_stall),
    .o_reg_wr_en  (o_reg_wr_en),
    .o_reg_wr_addr(o_reg_wr_addr),
    .o_reg_wr_val (o_reg_wr_val),
    .o_dbg_state  (o_dbg_state)
  );

  // Clock / reset block
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // The mc unit must keep valid/addr/val stable until a transfer
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      held_pend = 1'b0;
    end else begin
      if (held_pend) begin
        checks++;
        assert (i_mc_valid === 1'b1 && i_mc_addr === held_a && i_mc_val === held_v) else begin
          errors++;
          $error("FAIL mc_stable: observed v=%0b a=%0d d=0x%0h expected v=1 a=%0d d=0x%0h",
                 i_mc_valid, i_mc_addr, i_mc_val, held_a, held_v);
        end
      end
      held_pend = i_mc_valid && !o_mc_ready;
      held_a    = i_mc_addr;
      held_v    = i_mc_val;
    end
  end

  // Driver + scoreboard for one clock cycle
  task automatic step(input logic pe, input logic [4:0] pa, input logic [31:0] pv,
                      input logic mv, input logic [4:0] ma, input logic [31:0] mval);
    logic        pl_live, force_now, mc_win, pl_win;
    logic [37:0] prev;
    i_pl_wr_en   = pe;
    i_pl_wr_addr = pa;
    i_pl_wr_val  = pv;
    i_mc_valid   = mv;
    i_mc_addr    = ma;
    i_mc_val     = mval;
    #1;
    pl_live   = pe && (pa != 5'd0);
    force_now = mv && (lost >= LIMIT);
    mc_win    = force_now || (mv && !pl_live);
    pl_win    = pl_live && !force_now;
    check("mc_ready", {31'd0, o_mc_ready}, {31'd0, mc_win});
    check("pl_stall", {31'd0, o_pl_stall}, {31'd0, force_now});
    prev = exp_q.pop_front();
    check("wr_en", {31'd0, o_reg_wr_en}, {31'd0, prev[37]});
    if (prev[37]) begin
      check("wr_addr", {27'd0, o_reg_wr_addr}, {27'd0, prev[36:32]});
      check("wr_val", o_reg_wr_val, prev[31:0]);
    end
    if (pl_win)                     exp_q.push_back({1'b1, pa, pv});
    else if (mc_win && ma != 5'd0)  exp_q.push_back({1'b1, ma, mval});
    else                            exp_q.push_back(38'd0);
    if (mc_win || !mv) lost = 0;
    else               lost++;
    last_mc_taken = mc_win && mv;
    @(posedge i_clk);
    #1;
  endtask

  task automatic reset_and_check(input string tag);
    i_rst = 1'b1;
    #1;
    check({tag, "_wr_en"},   {31'd0, o_reg_wr_en}, 32'd0);
    check({tag, "_wr_addr"}, {27'd0, o_reg_wr_addr}, 32'd0);
    check({tag, "_wr_val"},  o_reg_wr_val, 32'd0);
    check({tag, "_stall"},   {31'd0, o_pl_stall}, 32'd0);
    check({tag, "_ready"},   {31'd0, o_mc_ready}, 32'd0);
    check({tag, "_state"},   {30'd0, o_dbg_state}, {30'd0, ST_IDLE});
    @(posedge i_clk);
    #1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(38'd0);
    lost = 0;
  endtask

  initial begin
    int pl_pct;
    logic pe;
    logic [4:0] pa;
    i_rst        = 1'b1;
    i_pl_wr_en   = 1'b0;
    i_pl_wr_addr = '0;
    i_pl_wr_val  = '0;
    i_mc_valid   = 1'b0;
    i_mc_addr    = '0;
    i_mc_val     = '0;
    @(posedge i_clk);
    #1;
    reset_and_check("reset");

    // Pipeline write only
    step(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, 32'd0);
    // Multi-cycle write with the pipeline idle
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_1234);
    // Starvation: pipeline every cycle, x9 held until forced through
    for (int k = 0; k < LIMIT + 1; k++)
      step(1'b1, 5'(10 + k), 32'hC0DE_0000 + k, 1'b1, 5'd9, 32'h55);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    // x0 writes from both sides
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    // Same-address collision: pipeline first, multi-cycle next
    step(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 32'h2);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h2);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    // Reset in WAIT after three lost cycles
    for (int k = 0; k < 3; k++)
      step(1'b1, 5'd12, 32'hA0 + k, 1'b1, 5'd20, 32'h7777);
    check("pre_reset_state", {30'd0, o_dbg_state}, {30'd0, ST_WAIT});
    reset_and_check("mid_wait_reset");
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h7777);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Random traffic with varying pipeline pressure
    for (int blk = 0; blk < 6; blk++) begin
      pl_pct = (blk % 3 == 0) ? 100 : ((blk % 3 == 1) ? 85 : 40);
      for (int c = 0; c < 60; c++) begin
        if (!mc_pend && $urandom_range(0, 3) == 0) begin
          mc_pend = 1'b1;
          mc_a    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          mc_v    = $urandom;
        end
        pe = ($urandom_range(0, 99) < pl_pct);
        pa = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        step(pe, pa, $urandom, mc_pend, mc_pend ? mc_a : 5'd0, mc_pend ? mc_v : 32'd0);
        if (last_mc_taken) mc_pend = 1'b0;
      end
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
